// File: rtl/qam16_symbol_mapper_pkg.sv
// Shared types and constants for the 16-QAM symbol mapper: FSM states,
// per-axis level codes, level multipliers and dmod field positions.
package mod_pkg;

  typedef enum logic {IDLE, TX} state_t;

  localparam logic [1:0] CODE_00 = 2'b00;
  localparam logic [1:0] CODE_01 = 2'b01;
  localparam logic [1:0] CODE_10 = 2'b10;
  localparam logic [1:0] CODE_11 = 2'b11;

  localparam int LVL_N3 = -3;
  localparam int LVL_N1 = -1;
  localparam int LVL_P1 = 1;
  localparam int LVL_P3 = 3;

  localparam int LAST_BIT = 4;
  localparam int I_MSB    = 3;
  localparam int Q_MSB    = 1;

endpackage

// File: rtl/qam16_symbol_mapper_if.sv
// Symbol-in / sample-out bundle of the mapper: RAM-side ready/valid handshake
// plus DAC-side strobe and I/Q samples. master = upstream/DAC side, slave = mapper.
interface qam16_symbol_mapper_if #(
  parameter int OW = 8
) ();
  logic [4:0]           dmod;
  logic                 mod_en;
  logic                 mod_rdy;
  logic                 dac_en;
  logic signed [OW-1:0] i_out;
  logic signed [OW-1:0] q_out;
  logic                 iq_valid;
  logic                 sym_last;

  modport master (
    output dmod, mod_en, dac_en,
    input  mod_rdy, i_out, q_out, iq_valid, sym_last
  );

  modport slave (
    input  dmod, mod_en, dac_en,
    output mod_rdy, i_out, q_out, iq_valid, sym_last
  );
endinterface

// File: rtl/qam16_symbol_mapper_level_map.sv
// Combinational per-axis 2-bit code -> signed level (+/-AMP, +/-3*AMP).
// Define MOD_GRAY_EN for Gray per-axis mapping; natural binary otherwise.
module qam16_level_map
  import mod_pkg::*;
#(
  parameter int OW  = 8,
  parameter int AMP = 32
) (
  input  logic [1:0]           code,
  output logic signed [OW-1:0] level
);

  localparam logic signed [OW-1:0] L_N3 = OW'(LVL_N3 * AMP);
  localparam logic signed [OW-1:0] L_N1 = OW'(LVL_N1 * AMP);
  localparam logic signed [OW-1:0] L_P1 = OW'(LVL_P1 * AMP);
  localparam logic signed [OW-1:0] L_P3 = OW'(LVL_P3 * AMP);

  always_comb begin
    level = '0;
    case (code)
`ifdef MOD_GRAY_EN
      CODE_00: level = L_N3;
      CODE_01: level = L_N1;
      CODE_11: level = L_P1;
      CODE_10: level = L_P3;
`else
      CODE_00: level = L_N3;
      CODE_01: level = L_N1;
      CODE_10: level = L_P1;
      CODE_11: level = L_P3;
`endif
    endcase
  end

endmodule

// File: rtl/qam16_symbol_mapper.sv
// 16-QAM symbol mapper: two-deep symbol buffer (cur + hold), each symbol held for
// SPS dac_en strobes. Mapping selected by MOD_GRAY_EN inside qam16_level_map.
//
// state | meaning
// IDLE  | no live symbol, outputs zero, waiting for a symbol
// TX    | cur symbol on i_out/q_out, cnt counts dac_en strobes
module qam16_symbol_mapper
  import mod_pkg::*;
#(
  parameter int SPS = 4,
  parameter int OW  = 8,
  parameter int AMP = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  qam16_symbol_mapper_if.slave bus
);

  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [4:0]      cur_sym, cur_nxt;
  logic [4:0]      hold_sym, hold_nxt;
  logic            hold_valid, hold_valid_nxt;
  logic            accept;
  logic signed [OW-1:0] lvl_i, lvl_q;

  assign accept = bus.mod_en && bus.mod_rdy;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cur_nxt        = cur_sym;
    hold_nxt       = hold_sym;
    hold_valid_nxt = hold_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          cur_nxt   = bus.dmod;
          cnt_nxt   = '0;
          state_nxt = TX;
        end
      end
      TX: begin
        if (bus.dac_en && cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (hold_valid) begin
            cur_nxt        = hold_sym;
            hold_valid_nxt = 1'b0;
            if (accept) begin
              hold_nxt       = bus.dmod;
              hold_valid_nxt = 1'b1;
            end
          end else if (accept) begin
            cur_nxt = bus.dmod;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (bus.dac_en) cnt_nxt = cnt + CW'(1);
          if (accept) begin
            hold_nxt       = bus.dmod;
            hold_valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  qam16_level_map #(.OW(OW), .AMP(AMP)) u_map_i (
    .code  (cur_nxt[I_MSB -: 2]),
    .level (lvl_i)
  );

  qam16_level_map #(.OW(OW), .AMP(AMP)) u_map_q (
    .code  (cur_nxt[Q_MSB -: 2]),
    .level (lvl_q)
  );

  // Outputs are registered from the next-state symbol so they change on the
  // same edge as cur and stay constant for the whole symbol.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_sym      <= '0;
      hold_sym     <= '0;
      hold_valid   <= 1'b0;
      bus.mod_rdy  <= 1'b1;
      bus.i_out    <= '0;
      bus.q_out    <= '0;
      bus.iq_valid <= 1'b0;
      bus.sym_last <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cur_sym      <= cur_nxt;
      hold_sym     <= hold_nxt;
      hold_valid   <= hold_valid_nxt;
      bus.mod_rdy  <= !hold_valid_nxt;
      bus.iq_valid <= (state_nxt == TX);
      bus.sym_last <= (state_nxt == TX) && cur_nxt[LAST_BIT];
      bus.i_out    <= (state_nxt == TX) ? lvl_i : '0;
      bus.q_out    <= (state_nxt == TX) ? lvl_q : '0;
    end
  end

endmodule

// File: tb/tb_qam16_symbol_mapper.sv
// Self-checking bench for qam16_symbol_mapper: sample-queue reference model,
// directed scenarios plus a randomized run.
module tb_qam16_symbol_mapper;

  localparam int SPS = 4;
  localparam int OW  = 8;
  localparam int AMP = 32;

  typedef struct {
    int i;
    int q;
    bit last;
  } samp_t;

  logic clk;
  logic reset_n;
  qam16_symbol_mapper_if #(.OW(OW)) bus ();

  qam16_symbol_mapper #(.SPS(SPS), .OW(OW), .AMP(AMP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  samp_t exp_q[$];
  int valid_cycles;
  bit seen_valid, seen_drop, gap;

  function automatic int lvl(logic [1:0] c);
    int b;
    b = int'(c);
`ifdef MOD_GRAY_EN
    b = int'({c[1], c[1] ^ c[0]});
`endif
    return (2 * b - 3) * AMP;
  endfunction

  // A symbol occupies SPS queued samples; two pending symbols fill both slots.
  function automatic bit model_rdy();
    return ((exp_q.size() + SPS - 1) / SPS) < 2;
  endfunction

  task automatic clear_stats();
    valid_cycles = 0;
    seen_valid = 0;
    seen_drop = 0;
    gap = 0;
  endtask

  task automatic step(input bit en, input logic [4:0] d, input bit dac);
    bit exp_rdy, acc, stb;
    logic [2*OW+1:0] got, want;
    samp_t s;
    bus.mod_en = en;
    bus.dmod   = d;
    bus.dac_en = dac;
    #1;
    exp_rdy = model_rdy();
    n_checks++;
    if (bus.mod_rdy !== exp_rdy)
      $display("FAIL mod_rdy t=%0t got=%b exp=%b", $time, bus.mod_rdy, exp_rdy);
    else n_pass++;
    got = {bus.iq_valid, bus.sym_last, bus.i_out, bus.q_out};
    if (exp_q.size() == 0) want = '0;
    else want = {1'b1, exp_q[0].last, OW'(exp_q[0].i), OW'(exp_q[0].q)};
    n_checks++;
    if (got !== want)
      $display("FAIL sample t=%0t got{v,l,i,q}=%h exp=%h", $time, got, want);
    else n_pass++;
    if (bus.iq_valid === 1'b1) begin
      valid_cycles++;
      if (seen_drop) gap = 1;
      seen_valid = 1;
    end else if (seen_valid) seen_drop = 1;
    acc = en && exp_rdy;
    stb = dac && (exp_q.size() > 0);
    @(posedge clk);
    if (stb) void'(exp_q.pop_front());
    if (acc) begin
      s.i = lvl(d[3:2]);
      s.q = lvl(d[1:0]);
      s.last = d[4];
      repeat (SPS) exp_q.push_back(s);
    end
    @(negedge clk);
  endtask

  task automatic send_wait(input logic [4:0] d, input bit dac, output int waited);
    bit acc;
    waited = 0;
    for (int t = 0; t < 64; t++) begin
      acc = model_rdy();
      step(1'b1, d, dac);
      if (acc) return;
      waited++;
    end
    n_checks++;
    $display("FAIL send_timeout sym=%h waited=%0d limit=64", d, waited);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) step(1'b0, 5'h00, 1'b1);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
    else n_pass++;
    step(1'b0, 5'h00, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    logic [2*OW+2:0] got;
    got = {bus.mod_rdy, bus.iq_valid, bus.sym_last, bus.i_out, bus.q_out};
    n_checks++;
    if (got !== {1'b1, {(2*OW+2){1'b0}}})
      $display("FAIL %s got{rdy,v,l,i,q}=%h exp=%h", tag, got, {1'b1, {(2*OW+2){1'b0}}});
    else n_pass++;
  endtask

  // Asserts reset away from the clock edge so the async path is exercised.
  task automatic async_reset(input int cycles);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    bus.mod_en = 1'b1;
    bus.dmod   = 5'($urandom);
    bus.dac_en = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      check_zero("reset_hold");
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.mod_en = 1'b1;
    bus.dmod   = 5'h1B;
    bus.dac_en = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    async_reset(3);
    step(1'b0, 5'h00, 1'b0);
  endtask

  task automatic test_single();
    logic signed [OW-1:0] ei, eq;
`ifdef MOD_GRAY_EN
    ei = 8'sd96;  eq = 8'sd32;
`else
    ei = 8'sd32;  eq = 8'sd96;
`endif
    clear_stats();
    step(1'b1, 5'h1B, 1'b1);
    n_checks++;
    if (bus.i_out !== ei || bus.q_out !== eq || bus.sym_last !== 1'b1)
      $display("FAIL single_levels got i=%0d q=%0d l=%b exp i=%0d q=%0d l=1",
               bus.i_out, bus.q_out, bus.sym_last, ei, eq);
    else n_pass++;
    drain();
    n_checks++;
    if (valid_cycles != SPS) $display("FAIL single_len got=%0d exp=%0d", valid_cycles, SPS);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w;
    clear_stats();
    send_wait(5'h00, 1'b1, w);
    send_wait(5'h0F, 1'b1, w);
    send_wait(5'h05, 1'b1, w);
    drain();
    n_checks++;
    if (valid_cycles != 3 * SPS || gap)
      $display("FAIL b2b_contiguous got=%0d gap=%b exp=%0d gap=0", valid_cycles, gap, 3 * SPS);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int w;
    step(1'b1, 5'h03, 1'b0);
    step(1'b1, 5'h1C, 1'b0);
    repeat (3) step(1'b1, 5'h09, 1'b0);
    n_checks++;
    if (bus.mod_rdy !== 1'b0) $display("FAIL bp_stalled got=%b exp=0", bus.mod_rdy);
    else n_pass++;
    send_wait(5'h09, 1'b1, w);
    n_checks++;
    if (w != SPS) $display("FAIL bp_wait got=%0d exp=%0d", w, SPS);
    else n_pass++;
    drain();
  endtask

  task automatic test_gating();
    clear_stats();
    for (int i = 0; i < 30; i++)
      step(i < 2, (i == 0) ? 5'h06 : 5'h19, (i > 0) && (i % 3 == 0));
    n_checks++;
    if (valid_cycles != 2 * 3 * SPS || gap)
      $display("FAIL gating_len got=%0d gap=%b exp=%0d", valid_cycles, gap, 2 * 3 * SPS);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic signed [OW-1:0] e;
`ifdef MOD_GRAY_EN
    e = 8'sd96;
`else
    e = 8'sd32;
`endif
    step(1'b1, 5'h07, 1'b0);
    step(1'b1, 5'h12, 1'b1);
    step(1'b0, 5'h00, 1'b1);
    async_reset(2);
    step(1'b0, 5'h00, 1'b1);
    step(1'b1, 5'h0A, 1'b1);
    n_checks++;
    if (bus.i_out !== e || bus.q_out !== e || bus.iq_valid !== 1'b1)
      $display("FAIL post_reset_0A got i=%0d q=%0d v=%b exp i=%0d q=%0d v=1",
               bus.i_out, bus.q_out, bus.iq_valid, e, e);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    logic [4:0] d;
    bit en;
    d = 5'($urandom);
    for (int t = 0; t < 400; t++) begin
      en = ($urandom % 2) == 1;
      if (en && model_rdy()) begin
        step(1'b1, d, ($urandom % 4) != 0);
        d = 5'($urandom);
      end else begin
        step(en, d, ($urandom % 4) != 0);
      end
    end
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.mod_en = 1'b0;
    bus.dmod = '0;
    bus.dac_en = 1'b0;
    clear_stats();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gating();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t limit=2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
